// File: rtl/jk_reg_bank.sv
// jk_reg_bank: a bank of WIDTH independent JK flip-flops that share one clock,
// enable and parallel-load path. Each bit follows the JK rule (hold / clear /
// set / toggle) when enabled; a load overrides the JK update for every bit.
//
// Alongside the bank state it keeps:
//   - changed    : per-bit flag, high for one cycle after a bit transitions
//   - change_cnt : saturating count of edges on which any bit of q changed
//   - cnt_sat    : registered flag, high while change_cnt is at its maximum
//
// Optional feature (macro JK_REG_BANK_PARITY_EN): adds a registered parity
// output equal to ^q, updated on the same edge as q.
//
// Ports:
//   clk        in   1      clock, all state updates on the rising edge
//   resetn     in   1      synchronous reset, active-low, overrides all inputs
//   en         in   1      global enable for the JK update
//   load       in   1      parallel load strobe, wins over en/j/k
//   d          in   WIDTH  parallel load data
//   j, k       in   WIDTH  per-bit J and K
//   cnt_clr    in   1      synchronous clear of the change counter
//   q          out  WIDTH  bank state
//   changed    out  WIDTH  bits of q that changed on the most recent edge
//   change_cnt out  CNT_W  number of edges on which q changed (saturating)
//   cnt_sat    out  1      high while change_cnt == 2^CNT_W-1
//   parity     out  1      ^q, registered (only with JK_REG_BANK_PARITY_EN)
//
// All outputs come straight from flops; there is no combinational input to
// output path.

module jk_reg_bank #(
    parameter int unsigned          WIDTH     = 8,
    parameter int unsigned          CNT_W     = 8,
    parameter logic [WIDTH-1:0]     RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] changed,
    output logic [CNT_W-1:0] change_cnt,
    output logic             cnt_sat
`ifdef JK_REG_BANK_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [WIDTH-1:0] q_d;
    logic [CNT_W-1:0] cnt_d;
    logic             sat_d;
    logic             change_event;

    // Next bank state: load beats the JK update, disabled JK holds.
    always_comb begin
        q_d = q;
        if (load) begin
            q_d = d;
        end else if (en) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                unique case ({j[i], k[i]})
                    2'b00:   q_d[i] = q[i];
                    2'b01:   q_d[i] = 1'b0;
                    2'b10:   q_d[i] = 1'b1;
                    2'b11:   q_d[i] = ~q[i];
                    default: q_d[i] = q[i];
                endcase
            end
        end
    end

    assign change_event = (q_d != q);

    // Clear wins over a simultaneous event; the counter never wraps.
    always_comb begin
        cnt_d = change_cnt;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (change_event && (change_cnt != CntMax)) begin
            cnt_d = change_cnt + 1'b1;
        end
    end

    // Registered saturation flag tracks the counter value it is stored with.
    assign sat_d = (cnt_d == CntMax);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            q          <= RESET_VAL;
            changed    <= '0;
            change_cnt <= '0;
            cnt_sat    <= 1'b0;
        end else begin
            q          <= q_d;
            changed    <= q_d ^ q;
            change_cnt <= cnt_d;
            cnt_sat    <= sat_d;
        end
    end

`ifdef JK_REG_BANK_PARITY_EN
    // Computed from q_d so parity is valid in the same cycle as q.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            parity <= ^RESET_VAL;
        end else begin
            parity <= ^q_d;
        end
    end
`endif

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed, table-driven bench for jk_reg_bank with WIDTH=4, CNT_W=3,
// RESET_VAL=0. Each table row gives the inputs for one edge and the
// hand-computed outputs expected just after that edge. A short hand-written
// sequence afterwards checks that reset only acts on a clock edge.

module tb_jk_reg_bank;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 3;

    logic             clk;
    logic             resetn;
    logic             en;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             cnt_clr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] changed;
    logic [CNT_W-1:0] change_cnt;
    logic             cnt_sat;
`ifdef JK_REG_BANK_PARITY_EN
    logic             parity;
`endif

    int errors = 0;
    int checks = 0;

    jk_reg_bank #(
        .WIDTH     (WIDTH),
        .CNT_W     (CNT_W),
        .RESET_VAL (4'h0)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .en         (en),
        .load       (load),
        .d          (d),
        .j          (j),
        .k          (k),
        .cnt_clr    (cnt_clr),
        .q          (q),
        .changed    (changed),
        .change_cnt (change_cnt),
        .cnt_sat    (cnt_sat)
`ifdef JK_REG_BANK_PARITY_EN
        ,
        .parity     (parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       resetn;
        logic       load;
        logic       en;
        logic       cnt_clr;
        logic [3:0] d;
        logic [3:0] j;
        logic [3:0] k;
        logic [3:0] exp_q;
        logic [3:0] exp_changed;
        logic [2:0] exp_cnt;
        logic       exp_sat;
    } vec_t;

    vec_t vecs[23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] eq, input logic [3:0] ec,
                                 input logic [2:0] ecnt, input logic esat);
        chk({tag, " q"}, 32'(q), 32'(eq));
        chk({tag, " changed"}, 32'(changed), 32'(ec));
        chk({tag, " change_cnt"}, 32'(change_cnt), 32'(ecnt));
        chk({tag, " cnt_sat"}, 32'(cnt_sat), 32'(esat));
`ifdef JK_REG_BANK_PARITY_EN
        chk({tag, " parity"}, 32'(parity), 32'(^eq));
`endif
    endtask

    initial begin
        //            rst ld en clr  d      j      k      q      chg    cnt   sat
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 3'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 3'd0, 1'b0};
        // Load 0101 with the counter cleared in the same edge.
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'h5, 4'h0, 4'h0, 4'h5, 4'h5, 3'd0, 1'b0};
        // Mixed JK: bit3 toggle, bit2 set, bit1 clear, bit0 hold.
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'hC, 4'hA, 4'hD, 4'h8, 3'd1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'hC, 4'hA, 4'hD, 4'h0, 3'd1, 1'b0};
        // Load beats en/j/k, then a reload of the same value flags nothing.
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'hA, 4'hF, 4'hF, 4'hA, 4'h7, 3'd2, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'hA, 4'hF, 4'hF, 4'hA, 4'h0, 3'd2, 1'b0};
        // Nine toggling edges on bit0: counter sticks at 7.
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h1, 4'h1, 4'hB, 4'h1, 3'd3, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h1, 4'h1, 4'hA, 4'h1, 3'd4, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h1, 4'h1, 4'hB, 4'h1, 3'd5, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h1, 4'h1, 4'hA, 4'h1, 3'd6, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h1, 4'h1, 4'hB, 4'h1, 3'd7, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h1, 4'h1, 4'hA, 4'h1, 3'd7, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h1, 4'h1, 4'hB, 4'h1, 3'd7, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h1, 4'h1, 4'hA, 4'h1, 3'd7, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h1, 4'h1, 4'hB, 4'h1, 3'd7, 1'b1};
        // Clear collides with a toggle: q toggles, counter reads 0.
        vecs[16] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 4'h1, 4'h1, 4'hA, 4'h1, 3'd0, 1'b0};
        // Enabled hold, clear-all, set-all.
        vecs[17] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'hA, 4'h0, 3'd0, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'hF, 4'h0, 4'hA, 3'd1, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'hF, 4'h0, 4'hF, 4'hF, 3'd2, 1'b0};
        // Reset mid-sequence discards a pending load.
        vecs[20] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h3, 4'hF, 4'hF, 4'h0, 4'h0, 3'd0, 1'b0};
        // Load 0111 (odd parity), then toggle bit0 to 0110 (even parity).
        vecs[21] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h7, 4'h0, 4'h0, 4'h7, 4'h7, 3'd1, 1'b0};
        vecs[22] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h1, 4'h1, 4'h6, 4'h1, 3'd2, 1'b0};

        for (int i = 0; i < 23; i++) begin
            resetn  = vecs[i].resetn;
            load    = vecs[i].load;
            en      = vecs[i].en;
            cnt_clr = vecs[i].cnt_clr;
            d       = vecs[i].d;
            j       = vecs[i].j;
            k       = vecs[i].k;
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_changed,
                          vecs[i].exp_cnt, vecs[i].exp_sat);
        end

        // Reset is synchronous: asserting it mid-cycle must not touch q.
        resetn  = 1'b1;
        load    = 1'b0;
        en      = 1'b0;
        cnt_clr = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("async q before edge", 32'(q), 32'h6);
        chk("async cnt before edge", 32'(change_cnt), 32'd2);
        @(posedge clk);
        #1;
        check_outputs("sync reset", 4'h0, 4'h0, 3'd0, 1'b0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("post reset idle", 4'h0, 4'h0, 3'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
